// File: rtl/prog_counter_pkg.sv
// counter_pkg: shared types for the programmable counter
package counter_pkg;
  typedef enum logic [1:0] {
    CNT_WRAP    = 2'd0,
    CNT_SAT     = 2'd1,
    CNT_ONESHOT = 2'd2
  } cnt_mode_e;
endpackage

// File: rtl/prog_counter_if.sv
// prog_counter_if: control/status bundle of prog_counter; slave is the counter side
interface prog_counter_if #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
);
  logic                  en_i;
  logic                  clr_i;
  logic                  load_i;
  logic [WIDTH-1:0]      load_val_i;
  logic                  dir_i;
  logic [1:0]            mode_i;
  logic [WIDTH-1:0]      limit_i;
  logic [PRESCALE_W-1:0] prescale_i;
  logic [WIDTH-1:0]      count_o;
  logic                  tc_o;
  logic                  done_o;
  modport master (
    output en_i, clr_i, load_i, load_val_i, dir_i, mode_i, limit_i, prescale_i,
    input  count_o, tc_o, done_o
  );
  modport slave (
    input  en_i, clr_i, load_i, load_val_i, dir_i, mode_i, limit_i, prescale_i,
    output count_o, tc_o, done_o
  );
endinterface

// File: rtl/prog_counter_prescaler.sv
// counter_prescaler: emits tick every div+1 enabled cycles; a lowered div ticks at once
module counter_prescaler #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] div,
  output logic             tick
);
  logic [WIDTH-1:0] cnt;
  assign tick = en && (cnt >= div);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/prog_counter.sv
// prog_counter: prescaled up/down counter with wrap, saturate and one-shot limits
module prog_counter
  import counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input logic           clk_i,
  input logic           rst_ni,
  prog_counter_if.slave bus
);
  logic [WIDTH-1:0] count, step_val, term;
  logic             tc, done, tick, hold, at_end, step_tc;
  counter_prescaler #(.WIDTH(PRESCALE_W)) u_pre (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en    (bus.en_i && !done),
    .clr   (bus.clr_i || bus.load_i),
    .div   (bus.prescale_i),
    .tick  (tick)
  );
  // Wrapping onto the terminal (limit 0) counts as an arrival; holding on it does not.
  always_comb begin
    hold     = (bus.mode_i == CNT_SAT) || (bus.mode_i == CNT_ONESHOT);
    term     = bus.dir_i ? bus.limit_i : '0;
    at_end   = bus.dir_i ? (count >= bus.limit_i) : (count == '0);
    step_val = at_end ? (hold ? count : (bus.dir_i ? '0 : bus.limit_i))
                      : (bus.dir_i ? count + 1'b1 : count - 1'b1);
    step_tc  = at_end ? (!hold && bus.limit_i == '0) : (step_val == term);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      count <= '0;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else if (bus.clr_i || bus.load_i) begin
      count <= bus.clr_i ? '0 : bus.load_val_i;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      tc <= tick && step_tc;
      if (tick) count <= step_val;
      if (tick && step_tc && bus.mode_i == CNT_ONESHOT) done <= 1'b1;
    end
  assign bus.count_o = count;
  assign bus.tc_o    = tc;
  assign bus.done_o  = done;
endmodule

// File: doc/prog_counter.md
# prog_counter

Parametrised, programmable successor to the team's fixed 4-bit free-running counter. Counts up or down at a programmable prescaled rate, supports synchronous clear and parallel load, and selects wrap, saturate or one-shot behaviour at a runtime-programmable limit. It is the general-purpose timer/event counter instantiated by peripheral and test-harness logic wherever a fixed-width wrap counter no longer suffices.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (≥2)
- PRESCALE_W, 8, prescaler width in bits (≥1)

Ports:
- clk_i  in  1  single clock, rising-edge
- rst_ni  in  1  asynchronous, active-low reset; the sole reset of the block
- en_i  in  1  count enable; prescaler and counter hold while low
- clr_i  in  1  synchronous clear
- load_i  in  1  synchronous parallel load
- load_val_i  in  WIDTH  value taken on load
- dir_i  in  1  1 = up, 0 = down
- mode_i  in  2  cnt_mode_e: WRAP, SAT, ONESHOT (encoding 3 behaves as WRAP)
- limit_i  in  WIDTH  terminal value for up-counting and wrap target for down-counting
- prescale_i  in  PRESCALE_W  step every prescale_i+1 enabled cycles
- count_o  out  WIDTH  current count
- tc_o  out  1  one-cycle terminal-count pulse
- done_o  out  1  ONESHOT finished, sticky

## Operation
- Reset (rst_ni low, asynchronous): count_o=0, tc_o=0, done_o=0, prescaler=0.
- Per-cycle priority: clr_i > load_i > step > hold.
- clr_i: count_o←0, prescaler←0, done_o←0, tc_o←0.
- load_i: count_o←load_val_i, prescaler←0, done_o←0, tc_o←0.
- Prescaler: advances only when en_i=1 and done_o=0. At prescale_i it returns to 0 and asserts an internal tick; otherwise it increments. prescale_i=0 gives a tick every enabled cycle. If prescale_i is lowered below the current prescaler value, the next enabled cycle produces a tick and returns the prescaler to 0.
- Step (on tick):
  - Up, terminal T=limit_i. If count_o≥T: WRAP→0, SAT→hold, ONESHOT→hold. Else count_o+1.
  - Down, terminal T=0. If count_o==0: WRAP→limit_i, SAT/ONESHOT→hold. Else count_o−1.
- tc_o: registered. Asserted in the cycle in which count_o first equals the terminal as the result of a step. It is not re-asserted while holding at the terminal in SAT or ONESHOT. In WRAP it pulses on each arrival at the terminal.
- done_o: set together with tc_o in ONESHOT. While set, steps are inhibited. Cleared only by clr_i, load_i or reset.
- Arithmetic is modulo 2^WIDTH, with no carry out. limit_i=0 in WRAP up gives a constant 0 and tc_o on every tick.
- Inputs mode_i, dir_i and limit_i are sampled every cycle; changes take effect on the next tick.

## Timing
- Load/clear latency: 1 cycle. count_o shows the new value on the edge after assertion.
- Step latency: count_o updates on the edge where the tick occurs. First step after an enable or load: prescale_i+1 enabled cycles.
- tc_o and done_o are coincident with the terminal value on count_o.
- Reset deassertion mid-operation: counting restarts from 0 with the prescaler at 0. rst_ni is synchronised externally.

## Structure
- counter_pkg: typedef enum logic [1:0] cnt_mode_e {CNT_WRAP=0, CNT_SAT=1, CNT_ONESHOT=2}.
- Sub-module counter_prescaler(WIDTH=PRESCALE_W), with inputs en, clr and div and output tick. The top level holds the count, tc and done registers and the next-state mux.

## Test plan
- Reset mid-count at count_o=0x37 → all outputs 0 asynchronously, before the next edge.
- WRAP up, limit=5, prescale=0 → 0,1,2,3,4,5,0,… with tc_o high exactly on each 5.
- SAT down, load 3, prescale=2 → 3,2,1,0, each value held 3 cycles, then holds 0; a single tc_o pulse.
- ONESHOT up, limit=0xFF, load 0xFD → FE, FF; tc_o and done_o assert at FF; count frozen with en_i high; load 0 clears done_o.
- clr_i and load_i asserted together with a tick → count_o=0 (clear wins); load_val ignored.
- WRAP up, load 0x20 with limit=0x10 → next tick yields 0 (≥ compare), and tc_o does not assert on that step.
